fir_tap_sequencer: RTL
======================

// Module: fir_tap_sequencer
// PURPOSE
//  Time-multiplexed controller/MAC for the FIR shift chain. Accepts one input sample per
//  valid/ready handshake and pulses the chain's enable to push the sample in. It then walks
//  tap_idx over all CHAIN_DEPTH taps, accumulating tap*coef, and presents one filtered output
//  sample on a valid/ready port. Sits between the sample source, the shiftchain/tap mux/coef ROM and the sink.
// PARAMETERS
//  WORD_WIDTH   16  sample/tap width, signed
//  COEF_WIDTH   16  coefficient width, signed
//  CHAIN_DEPTH  53  number of taps (= shiftchain depth), >=2
//  FRAC_BITS    15  coefficient fractional bits; output = acc >>> FRAC_BITS
// PORTS
//  clk        in   1                    clock, rising edge
//  reset      in   1                    asynchronous, active-high reset
//  in_valid   in   1                    input sample valid
//  in_ready   out  1                    high only in IDLE
//  in_data    in   WORD_WIDTH           signed input sample
//  shift_en   out  1                    one-cycle enable to shiftchain
//  shift_d    out  WORD_WIDTH           registered sample driven to shiftchain d
//  tap_idx    out  $clog2(CHAIN_DEPTH)  tap select to external mux and coef ROM
//  tap_data   in   WORD_WIDTH           signed q[tap_idx], combinational, same cycle
//  coef_data  in   COEF_WIDTH           signed coef[tap_idx], combinational, same cycle
//  out_valid  out  1                    filtered sample valid
//  out_ready  in   1                    sink ready
//  out_data   out  WORD_WIDTH           signed filtered sample
//  busy       out  1                    state != IDLE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, shift_en=0, shift_d=0, tap_idx=0, acc=0, out_valid=0,
//   out_data=0. A reset mid-MAC aborts with no partial output.
//  States: IDLE -> SHIFT -> MAC -> OUT -> IDLE.
//  IDLE: in_ready=1. On edge with in_valid: shift_d<=in_data; go to SHIFT.
//  SHIFT (1 cycle): shift_en=1; acc<=0; tap_idx=0. Next: MAC.
//   The chain updates on the edge that ends SHIFT, so q[0] holds the new sample during MAC.
//  MAC (CHAIN_DEPTH cycles): each edge acc<=acc+tap_data*coef_data and tap_idx<=tap_idx+1.
//   On the edge at tap_idx==CHAIN_DEPTH-1: out_data<=scale(final acc); tap_idx<=0; go to OUT.
//  OUT: out_valid=1. out_data is stable until the edge with out_ready=1, then go to IDLE.
//  Latency: out_valid rises CHAIN_DEPTH+1 edges after the accepting edge.
//   Minimum sample period with out_ready=1 is CHAIN_DEPTH+3 cycles.
//  in_valid outside IDLE is ignored (in_ready=0). shift_en is high only in SHIFT:
//   exactly one pulse per accepted sample.
//  Arithmetic: ACC_W = WORD_WIDTH+COEF_WIDTH+$clog2(CHAIN_DEPTH). The full-precision signed
//   accumulator never overflows. Scaling is an arithmetic shift >>> FRAC_BITS (floor).
//  tap_idx never exceeds CHAIN_DEPTH-1 and returns to 0 outside MAC.
// CONFIGURATION
//  FIR_SEQ_SATURATE_EN defined: the shifted result is clamped to
//   [-2^(WORD_WIDTH-1), 2^(WORD_WIDTH-1)-1].
//  FIR_SEQ_SATURATE_EN undefined: the shifted result is truncated to its low WORD_WIDTH bits
//   (two's-complement wrap).
// TESTING (defaults; tap_data and coef_data modelled as chain + ROM)
//  1 Reset: assert reset during MAC tap 20 -> all outputs 0 immediately; after release
//    in_ready=1, busy=0, no out_valid.
//  2 Impulse: coef[0]=16384, others 0, chain zeroed; accept 1000 -> one shift_en pulse with
//    shift_d=1000; out_valid exactly 54 edges after accept; out_data=500.
//  3 Sign: same coefs, sample -1000 -> out_data=-500. Sample -1 -> out_data=-1 (floor).
//  4 Busy: hold in_valid=1 continuously -> accepts spaced exactly 56 cycles apart.
//    in_ready=0 throughout SHIFT/MAC/OUT.
//  5 Backpressure: out_ready=0 for 10 cycles in OUT -> out_valid and out_data stable,
//    no shift_en, no accept; release -> IDLE next edge.
//  6 Overflow: all taps 32767, all coefs 32767 -> with FIR_SEQ_SATURATE_EN out_data=32767;
//    without it out_data=32662 (1736598 mod 65536).

Source files
------------

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR controller/MAC. Each accepted sample is pushed into an external shift
// chain, then all CHAIN_DEPTH taps are walked through tap_idx_o and tap*coef is accumulated.
// One scaled output sample is then held on a valid/ready port.
// Optional feature: define FIR_SEQ_SATURATE_EN to clamp the scaled result instead of wrapping.
module fir_tap_sequencer #(
    parameter int unsigned WORD_WIDTH  = 16,
    parameter int unsigned COEF_WIDTH  = 16,
    parameter int unsigned CHAIN_DEPTH = 53,
    parameter int unsigned FRAC_BITS   = 15,
    localparam int unsigned IdxW       = $clog2(CHAIN_DEPTH)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic signed [WORD_WIDTH-1:0] in_data_i,
    output logic                         shift_en_o,
    output logic        [WORD_WIDTH-1:0] shift_d_o,
    output logic        [IdxW-1:0]       tap_idx_o,
    input  logic signed [WORD_WIDTH-1:0] tap_data_i,
    input  logic signed [COEF_WIDTH-1:0] coef_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic signed [WORD_WIDTH-1:0] out_data_o,
    output logic                         busy_o
);

    localparam int unsigned ProdW = WORD_WIDTH + COEF_WIDTH;
    localparam int unsigned AccW  = WORD_WIDTH + COEF_WIDTH + $clog2(CHAIN_DEPTH);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(CHAIN_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StMac, StOut} state_e;

    state_e                        state_q, state_d;
    logic signed [WORD_WIDTH-1:0]  shift_data_q, shift_data_d;
    logic        [IdxW-1:0]        tap_idx_q, tap_idx_d;
    logic signed [AccW-1:0]        acc_q, acc_d;
    logic signed [WORD_WIDTH-1:0]  out_data_q, out_data_d;

    logic signed [ProdW-1:0]       product;
    logic signed [AccW-1:0]        acc_sum;
    logic signed [AccW-1:0]        shifted;
    logic signed [WORD_WIDTH-1:0]  scaled;
    logic                          last_tap;

    assign product  = tap_data_i * coef_data_i;
    assign acc_sum  = acc_q + AccW'(product);
    assign shifted  = acc_sum >>> FRAC_BITS;
    assign last_tap = (tap_idx_q == LastIdx);

`ifdef FIR_SEQ_SATURATE_EN
    localparam logic signed [AccW-1:0] SatMax =
        {{(AccW - WORD_WIDTH + 1){1'b0}}, {(WORD_WIDTH - 1){1'b1}}};
    localparam logic signed [AccW-1:0] SatMin =
        {{(AccW - WORD_WIDTH + 1){1'b1}}, {(WORD_WIDTH - 1){1'b0}}};

    // Clamp the floor-scaled sum into the output word range
    always_comb begin
        scaled = shifted[WORD_WIDTH-1:0];
        if (shifted > SatMax) begin
            scaled = {1'b0, {(WORD_WIDTH - 1){1'b1}}};
        end else if (shifted < SatMin) begin
            scaled = {1'b1, {(WORD_WIDTH - 1){1'b0}}};
        end
    end
`else
    // Two's-complement wrap: upper bits are intentionally dropped
    logic unused_shifted_msbs;
    assign unused_shifted_msbs = ^shifted[AccW-1:WORD_WIDTH];

    // Truncate the floor-scaled sum to the output word
    always_comb begin
        scaled = shifted[WORD_WIDTH-1:0];
    end
`endif

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> SHIFT -> MAC (CHAIN_DEPTH cycles) -> OUT -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid_i) state_d = StShift;
            StShift: state_d = StMac;
            StMac:   if (last_tap) state_d = StOut;
            StOut:   if (out_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake and strobe outputs decoded from the state
    always_comb begin
        in_ready_o  = 1'b0;
        shift_en_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
            end
            StShift: shift_en_o  = 1'b1;
            StOut:   out_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: capture sample, clear and run the MAC, latch the result
    always_comb begin
        shift_data_d = shift_data_q;
        tap_idx_d    = tap_idx_q;
        acc_d        = acc_q;
        out_data_d   = out_data_q;
        case (state_q)
            StIdle: if (in_valid_i) shift_data_d = in_data_i;
            StShift: begin
                acc_d     = '0;
                tap_idx_d = '0;
            end
            StMac: begin
                acc_d = acc_sum;
                if (last_tap) begin
                    tap_idx_d  = '0;
                    out_data_d = scaled;
                end else begin
                    tap_idx_d = tap_idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset aborts any MAC in flight without producing output
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shift_data_q <= '0;
            tap_idx_q    <= '0;
            acc_q        <= '0;
            out_data_q   <= '0;
        end else begin
            shift_data_q <= shift_data_d;
            tap_idx_q    <= tap_idx_d;
            acc_q        <= acc_d;
            out_data_q   <= out_data_d;
        end
    end

    assign shift_d_o  = shift_data_q;
    assign tap_idx_o  = tap_idx_q;
    assign out_data_o = out_data_q;

endmodule
